// File: rtl/sa_result_drain.sv
// sa_result_drain: streams all N*N PE accumulators to result memory, then clears them.
module sa_result_drain #(
    parameter int N     = 8,
    parameter int AW    = 10,
    parameter int ACC_W = 20,
    parameter int SW    = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sa_done,
    input  logic [AW-1:0]    base_addr,
    input  logic [ACC_W-1:0] acc_data,
    input  logic             wr_ready,
    output logic [SW-1:0]    row_sel,
    output logic [SW-1:0]    col_sel,
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    output logic [ACC_W-1:0] wr_data,
    output logic             clr_acc,
    output logic             busy,
    output logic             done
);
    localparam int IW = 2 * SW;
    localparam logic [IW-1:0] LAST = IW'(N * N - 1);

    typedef enum logic [2:0] {IDLE, WAIT_SA, DRAIN, CLEAR, DONE} state_t;

    state_t        state, state_n;
    logic [IW-1:0] idx;
    logic [AW-1:0] base_q;
    logic          accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? WAIT_SA : IDLE;
            WAIT_SA: state_n = sa_done ? DRAIN : WAIT_SA;
            DRAIN:   state_n = (accept && idx == LAST) ? CLEAR : DRAIN;
            CLEAR:   state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        wr_en   = state == DRAIN;
        clr_acc = state == CLEAR;
        done    = state == DONE;
        busy    = state != IDLE;
    end

    assign accept  = wr_en && wr_ready;
    assign wr_data = acc_data;
    assign row_sel = idx[IW-1:SW];
    assign col_sel = idx[SW-1:0];
    // Address wraps silently at 2^AW.
    assign wr_addr = base_q + AW'(idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            base_q <= '0;
        end else if (state == IDLE) begin
            idx <= '0;
            if (start) base_q <= base_addr;
        end else if (accept) begin
            idx <= idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_sa_result_drain.sv
// tb_sa_result_drain: vector table plus randomized back-pressure against an index-count model.
module tb_sa_result_drain;
    localparam int N = 8, AW = 10, ACC_W = 20, SW = 3;

    logic             clk = 1'b0, rst = 1'b1, start = 1'b0, sa_done = 1'b0, wr_ready = 1'b1;
    logic [AW-1:0]    base_addr = '0;
    logic [ACC_W-1:0] acc_data;
    logic [SW-1:0]    row_sel, col_sel;
    logic             wr_en, clr_acc, busy, done;
    logic [AW-1:0]    wr_addr;
    logic [ACC_W-1:0] wr_data;
    logic [ACC_W-1:0] pe_val [64];
    int               ncmp = 0, mism = 0;

    typedef struct {
        logic [9:0] base;
        int         wait_c;
        int         ready_pct;
        bit         ign;
        bit         drop;
        bit         pe_rand;
        logic [9:0] first;
        logic [9:0] last;
    } vec_t;

    vec_t vecs [6];

    sa_result_drain #(.N(N), .AW(AW), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .sa_done(sa_done), .base_addr(base_addr),
        .acc_data(acc_data), .wr_ready(wr_ready), .row_sel(row_sel), .col_sel(col_sel),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .clr_acc(clr_acc),
        .busy(busy), .done(done)
    );

    assign acc_data = pe_val[{row_sel, col_sel}];

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            mism++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_clr_acc", int'(clr_acc), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_row_sel", int'(row_sel), 0);
        chk("rst_col_sel", int'(col_sel), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
    endtask

    task automatic fill_pe(input bit rnd);
        for (int i = 0; i < 64; i++)
            pe_val[i] = rnd ? ACC_W'($urandom) : ACC_W'((i / N) * N + i % N);
    endtask

    // Model: write k goes to (base+k) mod 1024 from PE (k/N, k%N); it starts the cycle
    // after sa_done rises and is retired on each ready cycle.
    task automatic run(input vec_t v);
        int k = 0, stalls = 0, d, clr_at = 1 << 20, nwr = 0, ndone = 0, done_at = -1;
        logic [9:0] fa = '0, la = '0;
        bit fin = 1'b0;
        d = 2 + v.wait_c;
        fill_pe(v.pe_rand);
        for (int c = 0; c < 600 && !fin; c++) begin
            @(negedge clk);
            start     = (c == 0) || (v.ign && c == d + 10);
            base_addr = (c == 0) ? v.base : 10'h100;
            sa_done   = (c > v.wait_c) && !(v.drop && c > d + 3);
            wr_ready  = (c >= d && v.ready_pct < 100) ? ($urandom_range(99) < v.ready_pct) : 1'b1;
            #1;
            if (c == 0) continue;
            chk("busy", int'(busy), int'(c <= clr_at + 1));
            chk("wr_en", int'(wr_en), int'(c >= d && k < 64));
            chk("clr_acc", int'(clr_acc), int'(c == clr_at));
            chk("done", int'(done), int'(c == clr_at + 1));
            if (wr_en && wr_ready) begin
                nwr++;
                if (nwr == 1) fa = wr_addr;
                la = wr_addr;
            end
            if (done) begin
                ndone++;
                done_at = c;
            end
            if (c >= d && k < 64) begin
                chk("wr_addr", int'(wr_addr), (int'(v.base) + k) % 1024);
                chk("row_sel", int'(row_sel), k / N);
                chk("col_sel", int'(col_sel), k % N);
                chk("wr_data", int'(wr_data), int'(pe_val[k]));
                if (wr_ready) begin
                    k++;
                    if (k == 64) clr_at = c + 1;
                end else begin
                    stalls++;
                end
            end
            fin = (c == clr_at + 2);
        end
        start = 1'b0;
        if (!fin) begin
            mism++;
            $display("FAIL timeout: drain from base %0d never completed", v.base);
        end
        chk("write_count", nwr, 64);
        chk("done_count", ndone, 1);
        chk("done_cycle", done_at, d + 65 + stalls);
        chk("first_addr", int'(fa), int'(v.first));
        chk("last_addr", int'(la), int'(v.last));
    endtask

    initial begin
        vec_t rv;
        int nwr;
        vecs[0] = '{10'h040, 0,  100, 1'b0, 1'b0, 1'b0, 10'h040, 10'h07F};
        vecs[1] = '{10'h080, 20, 100, 1'b0, 1'b0, 1'b1, 10'h080, 10'h0BF};
        vecs[2] = '{10'h123, 0,  50,  1'b0, 1'b0, 1'b1, 10'h123, 10'h162};
        vecs[3] = '{10'h3F0, 3,  100, 1'b0, 1'b0, 1'b1, 10'h3F0, 10'h02F};
        vecs[4] = '{10'h020, 0,  60,  1'b1, 1'b1, 1'b1, 10'h020, 10'h05F};
        vecs[5] = '{10'h3E8, 0,  50,  1'b0, 1'b0, 1'b1, 10'h3E8, 10'h027};
        fill_pe(1'b0);
        #12;
        chk_reset_vals();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) run(vecs[i]);

        // Asynchronous reset part-way through a drain.
        @(negedge clk);
        base_addr = 10'h200;
        start = 1'b1;
        sa_done = 1'b1;
        wr_ready = 1'b1;
        nwr = 0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 100 && nwr < 10; c++) begin
            @(posedge clk);
            #2;
            if (wr_en && wr_ready) nwr++;
        end
        if (nwr < 10) begin
            mism++;
            $display("FAIL reset_setup: only %0d writes seen", nwr);
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_reset_vals();
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("post_rst_clr", int'(clr_acc), 0);
            chk("post_rst_done", int'(done), 0);
            chk("post_rst_busy", int'(busy), 0);
        end
        rv = '{10'h010, 0, 100, 1'b0, 1'b0, 1'b1, 10'h010, 10'h04F};
        run(rv);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, mism);
        $finish;
    end
endmodule

// File: doc/sa_result_drain.md
# sa_result_drain

Drains the 8x8 systolic array's PE accumulators to result memory once the load/compute sequence reports done. It steps a row/column select across all N*N PEs and writes each accumulator value to consecutive addresses from a latched base. It honours memory back-pressure and clears the accumulators after the last write. It sits between `SA_control`'s `done` output, the PE accumulator read mux and the result-memory write port.

## Interface

Parameters:
- `N`, 8: array dimension; N*N results are drained; must be a power of two.
- `AW`, 10: result memory address width.
- `ACC_W`, 20: accumulator/result data width.
- `SW`, $clog2(N): select width.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: drain request; sampled only in IDLE.
- `sa_done`, in, 1: level from the array controller; compute is complete.
- `base_addr`, in, AW: result base address; latched on an accepted `start`.
- `acc_data`, in, ACC_W: accumulator selected by `row_sel`/`col_sel`; driven by an external combinational mux and valid in the same cycle.
- `wr_ready`, in, 1: memory accepts a write when `wr_en && wr_ready`.
- `row_sel`, out, SW: PE row being read.
- `col_sel`, out, SW: PE column being read.
- `wr_en`, out, 1: write request.
- `wr_addr`, out, AW: write address.
- `wr_data`, out, ACC_W: equals `acc_data`, passed combinationally.
- `clr_acc`, out, 1: one-cycle pulse clearing all PE accumulators.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle completion pulse.

## Operation

- States: IDLE, WAIT_SA, DRAIN, CLEAR, DONE.
- **IDLE:**
  - `start`=1 -> WAIT_SA.
  - Latch `base_addr` into `base_q`.
  - Clear index counter `idx` (width 2*SW) to 0.
- **WAIT_SA:** remain until `sa_done`=1, then -> DRAIN.
- **DRAIN:**
  - Outputs: `wr_en`=1, `row_sel`=`idx[2*SW-1:SW]`, `col_sel`=`idx[SW-1:0]`, `wr_addr`=(`base_q`+`idx`) mod 2^AW.
  - Accepted write (`wr_en && wr_ready`): `idx` increments.
  - Accepted write with `idx`=N*N-1: -> CLEAR instead.
  - `wr_ready`=0: `idx`, selects, address and state all hold.
- **CLEAR:** `clr_acc`=1 for exactly one cycle -> DONE.
- **DONE:** `done`=1 for one cycle -> IDLE.
- `start` outside IDLE is ignored; `base_q` does not change.
- `sa_done` dropping during DRAIN is ignored; the drain completes.
- Address arithmetic wraps modulo 2^AW. No error is flagged, e.g. `base_addr`=1000 with N=8 wraps to 0..39 after 1023.
- `row_sel`, `col_sel` and `wr_addr` are registered (derived from registered `idx`/`base_q`). `wr_data` is not registered.

## Timing

- Reset (async assert, sync release):
  - State IDLE, `idx`=0, `base_q`=0.
  - `wr_en`=0, `clr_acc`=0, `done`=0, `busy`=0, `row_sel`=0, `col_sel`=0, `wr_addr`=0.
- Reset mid-drain aborts immediately. No `done`, no `clr_acc`; the remaining writes are lost.
- Back-to-back run with `sa_done` already high and `wr_ready`=1, taking `start` sampled at edge 0:
  - Cycle 1: WAIT_SA.
  - Cycles 2-65: DRAIN, 64 writes, addresses `base`..`base`+63.
  - Cycle 66: CLEAR.
  - Cycle 67: DONE.
  - Cycle 68: IDLE.
- Each cycle with `wr_ready`=0 during DRAIN adds exactly one cycle.
- `start` held high through DONE is sampled again in IDLE and begins a new run.
- `busy` is 1 from cycle 1 through cycle 67.

## Test plan

- **Basic drain:** reset, `base_addr`=0x040, `sa_done`=1, `wr_ready`=1, pulse `start`.
  - 64 writes to 0x040..0x07F in row-major order (row 0 cols 0-7 first).
  - `wr_data` matches a model PE value `r*8+c` each time.
  - `clr_acc` pulses at cycle 66 and `done` at cycle 67.
- **Wait for compute:** `start` with `sa_done`=0 for 20 cycles.
  - `wr_en` stays 0 and `busy`=1.
  - The first write occurs 1 cycle after `sa_done` rises.
- **Back-pressure:** random `wr_ready` (≈50%).
  - Exactly 64 accepted writes, no duplicated or skipped index.
  - Selects and address are stable while `wr_ready`=0.
  - `done` is delayed by exactly the number of stalled cycles.
- **Address wrap:** `base_addr`=0x3F0.
  - Writes go to 0x3F0..0x3FF, then 0x000..0x02F.
- **Ignored start:** pulse `start` with `base_addr`=0x100 mid-drain.
  - Addresses continue from the original base.
  - Exactly one `done`.
- **Async reset mid-drain:** assert `rst` after the 10th write, off a clock edge.
  - All outputs go to reset values immediately.
  - No `clr_acc` or `done`.
  - A subsequent `start` performs a full 64-write drain.
